// File: rtl/ascii_message_sequencer.sv
// Steps through a fixed ASCII message at a programmable rate for a single-digit
// 7-segment decoder, inserting blank gaps and folding '.' into the decimal point.
module ascii_message_sequencer #(
   parameter int unsigned             MSG_LEN        = 16,
   parameter logic [8*MSG_LEN-1:0]    MSG            = "HELLO FPGA 2024.",
   parameter int unsigned             TICKS_PER_STEP = 25000000,
   parameter int unsigned             BLANK_TICKS    = 2500000,
   parameter int unsigned             CNT_W          = 25,
   parameter int unsigned             IDX_W          = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             restart,
   output logic [6:0]       ascii_out,
   output logic             dp_out,
   output logic [IDX_W-1:0] char_idx,
   output logic             wrap
);

   localparam logic [6:0]       SPACE      = 7'h20;
   localparam logic [6:0]       DOT        = 7'h2E;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICKS_PER_STEP - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

   typedef enum logic {SHOW, BLANK} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [6:0]       ascii_nx;
   logic             dp_nx;
   logic [IDX_W-1:0] char_nx;
   logic             wrap_nx;

   function automatic logic [6:0] char_at(input int unsigned i);
      return MSG[8*(MSG_LEN-1-i) +: 7];
   endfunction

   // Returns {two_step, dp, ascii} for the character shown at index i.
   function automatic logic [8:0] show_rule(input int unsigned i);
      logic [6:0] c, n;
      c = char_at(i);
      n = char_at((i + 1) % MSG_LEN);
      if (c == DOT)
         return {1'b0, 1'b1, SPACE};
      else if (n == DOT && MSG_LEN > 1)
         return {1'b1, 1'b1, c};
      else
         return {1'b0, 1'b0, c};
   endfunction

   logic [8:0]  rule_cur, rule_zero;
   int unsigned sum;
   logic        advance;

   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      cnt_nx    = cnt;
      ascii_nx  = ascii_out;
      dp_nx     = dp_out;
      char_nx   = char_idx;
      wrap_nx   = 1'b0;
      advance   = 1'b0;
      rule_cur  = show_rule(int'(idx));
      rule_zero = show_rule(0);
      sum       = int'(idx) + (rule_cur[8] ? 2 : 1);

      // Restart loads MSG[0] onto the outputs directly so it appears even with run low.
      if (restart) begin
         state_nx = SHOW;
         idx_nx   = '0;
         cnt_nx   = '0;
         ascii_nx = rule_zero[6:0];
         dp_nx    = rule_zero[7];
         char_nx  = '0;
      end else if (run) begin
         char_nx = idx;
         if (state == SHOW) begin
            ascii_nx = rule_cur[6:0];
            dp_nx    = rule_cur[7];
            if (cnt == SHOW_LAST) begin
               cnt_nx = '0;
               if (BLANK_TICKS > 0)
                  state_nx = BLANK;
               else
                  advance = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end else begin
            ascii_nx = SPACE;
            dp_nx    = 1'b0;
            if (cnt == BLANK_LAST) begin
               cnt_nx   = '0;
               state_nx = SHOW;
               advance  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         if (advance) begin
            if (sum >= MSG_LEN) begin
               wrap_nx = 1'b1;
               idx_nx  = IDX_W'(sum - MSG_LEN);
            end else begin
               idx_nx  = IDX_W'(sum);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SHOW;
         idx       <= '0;
         cnt       <= '0;
         ascii_out <= SPACE;
         dp_out    <= 1'b0;
         char_idx  <= '0;
         wrap      <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         cnt       <= cnt_nx;
         ascii_out <= ascii_nx;
         dp_out    <= dp_nx;
         char_idx  <= char_nx;
         wrap      <= wrap_nx;
      end
   end

endmodule
